// File: rtl/fib_sequencer.sv
// fib_sequencer: Fibonacci term generator with a rotating register bank, step handshake and overflow policy
module fib_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    parameter logic [WIDTH-1:0] SEED_A = '0,
    parameter logic [WIDTH-1:0] SEED_B = WIDTH'(1),
    parameter bit SAT_MODE = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       step,
    input  logic [15:0]                num_terms,
    output logic [WIDTH-1:0]           term,
    output logic [15:0]                term_idx,
    output logic                       term_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       ovf,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]           rd_data
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {IDLE, SEED0, SEED1, RUN, DONE, OVF} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] bank [DEPTH];
    logic [WIDTH-1:0] bank_n [DEPTH];
    logic [WIDTH-1:0] term_n, wd;
    logic [15:0] idx_n, limit, limit_n;
    logic [AW-1:0] wp, wp_n, p1, p2, wp_inc;
    logic [WIDTH:0] sum;
    logic valid_n, ovf_n;
    assign p1 = (wp == '0) ? AW'(DEPTH - 1) : wp - AW'(1);
    assign p2 = (wp < AW'(2)) ? wp + AW'(DEPTH - 2) : wp - AW'(2);
    assign wp_inc = (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
    assign sum = {1'b0, bank[p1]} + {1'b0, bank[p2]};
    assign wd = (sum[WIDTH] && SAT_MODE) ? '1 : sum[WIDTH-1:0];
    assign busy = state inside {SEED0, SEED1, RUN};
    assign done = state inside {DONE, OVF};
    assign rd_data = (32'(rd_addr) < DEPTH) ? bank[rd_addr] : '0;
    always_comb begin
        state_n = state;
        bank_n = bank;
        term_n = term;
        idx_n = term_idx;
        wp_n = wp;
        limit_n = limit;
        ovf_n = ovf;
        valid_n = 1'b0;
        if (start) begin
            state_n = SEED0;
            limit_n = num_terms;
            ovf_n = 1'b0;
        end else begin
            case (state)
                SEED0: begin
                    bank_n[0] = SEED_A;
                    term_n = SEED_A;
                    idx_n = 16'd0;
                    valid_n = 1'b1;
                    state_n = SEED1;
                end
                SEED1: begin
                    bank_n[1] = SEED_B;
                    term_n = SEED_B;
                    idx_n = 16'd1;
                    valid_n = 1'b1;
                    wp_n = AW'(2);
                    state_n = (limit <= 16'd2) ? DONE : RUN;
                end
                RUN: if (step) begin
                    bank_n[wp] = wd;
                    term_n = wd;
                    idx_n = term_idx + 16'd1;
                    valid_n = 1'b1;
                    wp_n = wp_inc;
                    ovf_n = ovf | sum[WIDTH];
                    // saturation stop wins over reaching the final index
                    state_n = (sum[WIDTH] && SAT_MODE) ? OVF : (idx_n == limit - 16'd1) ? DONE : RUN;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
            term <= '0;
            term_idx <= '0;
            term_valid <= 1'b0;
            ovf <= 1'b0;
            wp <= '0;
            limit <= '0;
        end else begin
            state <= state_n;
            bank <= bank_n;
            term <= term_n;
            term_idx <= idx_n;
            term_valid <= valid_n;
            ovf <= ovf_n;
            wp <= wp_n;
            limit <= limit_n;
        end
    end
endmodule
